// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit.
// Owns the fetch PC and issues in-order word requests to instruction memory,
// buffers responses in a small FIFO, and presents {pc, instr} to decode.
// Redirects flush the FIFO and drop any responses still in flight.
// Optional build macro IF_PREFETCH_BYPASS_EN: a response that arrives while the
// FIFO is empty and nothing is being dropped is presented combinationally in
// the same cycle. It is written into the FIFO only if decode stalls.

module if_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW     = $clog2(DEPTH) + 1;
  localparam logic [CntW:0]   DepthOcc = (CntW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] Nop      = XLEN'(32'h0000_0013);

  // Fetch PC, instruction FIFO and in-order request-PC queue.
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [XLEN-1:0] pcq_q [DEPTH];
  logic [PtrW-1:0] pcq_rd_q, pcq_rd_d;
  logic [PtrW-1:0] pcq_wr_q, pcq_wr_d;
  // Requests accepted but not yet answered, and how many of those to discard.
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;

  logic [CntW:0] occupancy;
  logic          fifo_empty;
  logic          rsp_ok;
  logic          rsp_keep;
  logic          req_fire;
  logic          bypass;
  logic          pop;
  logic          fifo_pop;
  logic          fifo_push;

  // Request credit, response qualification and the decode-facing outputs.
  always_comb begin
    occupancy      = {1'b0, count_q} + {1'b0, outstanding_q};
    fifo_empty     = (count_q == '0);
    // A response with nothing outstanding is ignored entirely.
    rsp_ok         = !reset && imem_rsp_valid && (outstanding_q != '0);
    rsp_keep       = rsp_ok && (drop_q == '0);
    imem_req_valid = !reset && !redirect_valid && (occupancy < DepthOcc);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
`ifdef IF_PREFETCH_BYPASS_EN
    bypass         = fifo_empty && rsp_keep;
`else
    bypass         = 1'b0;
`endif
    if_valid       = !reset && (!fifo_empty || bypass);
    if_pc          = '0;
    if_instr       = Nop;
    if (if_valid) begin
      if (bypass) begin
        if_pc    = pcq_q[pcq_rd_q];
        if_instr = imem_rsp_data;
      end else begin
        if_pc    = fifo_pc_q[rd_ptr_q];
        if_instr = fifo_instr_q[rd_ptr_q];
      end
    end
    pop       = if_valid && !id_stall;
    fifo_pop  = pop && !fifo_empty;
    // A bypassed response that decode consumes never needs a FIFO slot.
    fifo_push = !redirect_valid && rsp_keep && !(bypass && pop);
  end

  // Next-state: redirect flushes everything and turns in-flight requests into drops.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    pcq_rd_d      = pcq_rd_q;
    pcq_wr_d      = pcq_wr_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc & ~XLEN'(3);
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      pcq_rd_d      = '0;
      pcq_wr_d      = '0;
      outstanding_d = outstanding_q - CntW'(rsp_ok);
      drop_d        = outstanding_q - CntW'(rsp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        pcq_wr_d   = pcq_wr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (fifo_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rsp_keep) begin
        pcq_rd_d = pcq_rd_q + 1'b1;
      end
      count_d       = count_q + CntW'(fifo_push) - CntW'(fifo_pop);
      outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_ok);
      if (rsp_ok && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pcq_rd_q      <= pcq_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Data storage; validity is tracked by the pointers and counts above.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
    if (req_fire) begin
      pcq_q[pcq_wr_q] <= fetch_pc_q;
    end
  end

`ifndef SYNTHESIS
  // Memory-side protocol error: every response must match an accepted request.
  rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outstanding_q != '0))
    else $error("if_prefetch_unit: response with no outstanding request");
`endif

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC-V core. Sits directly upstream of the IF_ID pipeline register.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned instructions in a small prefetch FIFO and presents {pc, instr} to the decode stage.
- Handles decode backpressure (stall) and control-flow redirects (branch/jal) with a full flush.

Parameters:
- XLEN, 32, address/instruction width.
- DEPTH, 4, prefetch FIFO entries; also the cap on occupancy plus outstanding requests; power of 2, 2..16.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in-order; one per accepted request; no backpressure.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  control-flow change from EX.
- redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored and treated as 0.
- id_stall  in  1  decode cannot accept this cycle.
- if_valid  out  1  if_pc/if_instr hold a real instruction.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  XLEN  presented instruction; 32'h0000_0013 (NOP) when if_valid=0.

Behaviour:
- Reset: synchronous. fetch_pc=RESET_PC; FIFO emptied; outstanding=0; drop=0.
  - Outputs during and after reset: imem_req_valid=0 during reset; if_valid=0; if_pc=0; if_instr=NOP.
- Request issue:
  - imem_req_valid=1 iff !reset && !redirect_valid && (count + outstanding) < DEPTH.
  - imem_req_addr=fetch_pc.
  - Request is accepted when imem_req_valid && imem_req_ready. On accept: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding += 1.
- Response:
  - When imem_rsp_valid and drop==0: push {pc_of_request, data}. The request PC is tracked in an in-order PC queue of depth DEPTH.
  - When imem_rsp_valid and drop>0: discard the response and decrement drop.
  - Every response decrements outstanding.
  - A response arriving with no outstanding request is illegal. It is asserted in simulation and ignored.
- Dequeue:
  - if_valid = (count != 0); head entry is presented.
  - Pop when if_valid && !id_stall.
  - Push and pop in the same cycle leave count unchanged.
  - FIFO is never overrun, because the credit rule in Request issue guarantees space.
- Redirect (highest priority):
  - Same cycle: imem_req_valid is forced to 0.
  - Next edge: FIFO cleared; PC queue cleared; fetch_pc=redirect_pc; drop = outstanding minus any response arriving this cycle; outstanding keeps counting responses.
  - if_valid=0 in the cycle after redirect.
  - First new request is issued the cycle after redirect, even while drop>0.
  - A pop coincident with redirect still counts as consumed.
- Stall: holds FIFO head stable; fetch continues until the credit limit is reached.
- Reset mid-operation: all in-flight responses are the memory's responsibility to abort. After reset the block assumes outstanding=0.
- Latency: accept-to-presented = memory latency + 1 cycle through the FIFO register.
- Throughput: 1 instr/cycle with 1-cycle memory when id_stall=0.

Optional Feature:
- Macro: IF_PREFETCH_BYPASS_EN.
- Defined: when FIFO is empty, drop==0, and imem_rsp_valid=1, the response drives if_valid/if_pc/if_instr combinationally in the same cycle.
  - It is pushed only if not consumed (id_stall=1).
  - Latency becomes memory latency + 0.
- Undefined: all responses pass through the FIFO (+1 cycle).
- Redirect semantics are identical in both builds.

Test Plan:
- Reset release, memory ready=1, latency 1, id_stall=0 -> requests at 0x0, 0x4, 0x8; if_pc sequence 0x0, 0x4, 0x8 with matching data; if_valid first high 2 cycles after first accept (1 with bypass).
- id_stall held high 10 cycles, DEPTH=4 -> exactly 4 requests issued in total (occupancy+outstanding=4), then imem_req_valid=0; head if_pc=0x0 stable; release -> 0x0..0xC drained in 4 consecutive cycles.
- 3 requests outstanding (latency 3), redirect_pc=0x100 -> 3 old responses dropped; next presented if_pc=0x100, then 0x104; no 0x0/0x4/0x8 instr ever presented after redirect.
- Redirect in same cycle as a response and pop -> response dropped; drop count correct; if_valid=0 next cycle; 0x200 is the next PC presented.
- fetch_pc=0xFFFF_FFFC, continuous fetch -> next imem_req_addr=0x0000_0000 (wrap).
- Synchronous reset asserted mid-stream with FIFO holding 3 entries -> next cycle if_valid=0, if_instr=0x0000_0013, first request after release is at RESET_PC.
